// File: rtl/prog_loader.sv
// Program loader and memory-port owner for the MP-8: streams an image into the
// 32x8 memory, optionally zero-fills the tail, then releases and starts the CPU.
module prog_loader #(
    parameter bit FILL_ZERO = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_req,
    input  logic [5:0] load_len,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    input  logic [4:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    input  logic       cpu_we,
    output logic [4:0] mem_addr,
    output logic [7:0] mem_din,
    output logic       mem_we,
    output logic       cpu_reset,
    output logic       cpu_start,
    output logic       busy,
    output logic       done,
    output logic [7:0] checksum
);
    typedef enum logic [2:0] {IDLE, LOAD, FILL, START, RUN} state_e;

    state_e     state_q, state_d;
    logic [5:0] len_q, len_d;
    logic [4:0] cnt_q, cnt_d;
    logic [7:0] sum_q, sum_d;
    logic [5:0] len_sel;
    logic       xfer;
    logic       last_byte;

    // A length of zero or anything beyond the memory size means a full image.
    assign len_sel   = (load_len == 6'd0 || load_len > 6'd32) ? 6'd32 : load_len;
    assign xfer      = (state_q == LOAD) && byte_valid;
    assign last_byte = xfer && ({1'b0, cnt_q} == (len_q - 6'd1));
    assign checksum  = sum_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= 6'd32;
            cnt_q   <= 5'd0;
            sum_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        sum_d      = sum_q;
        byte_ready = 1'b0;
        mem_addr   = 5'd0;
        mem_din    = 8'd0;
        mem_we     = 1'b0;
        cpu_reset  = 1'b1;
        cpu_start  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state_q)
            IDLE: begin
                if (load_req) begin
                    state_d = LOAD;
                    len_d   = len_sel;
                    cnt_d   = 5'd0;
                    sum_d   = 8'd0;
                end
            end
            LOAD: begin
                busy       = 1'b1;
                byte_ready = 1'b1;
                mem_addr   = cnt_q;
                mem_din    = byte_in;
                mem_we     = byte_valid;
                if (xfer) begin
                    sum_d = sum_q + byte_in;
                    // On a full image the counter holds at 31 instead of wrapping.
                    if (last_byte) begin
                        if (FILL_ZERO && (len_q < 6'd32)) begin
                            state_d = FILL;
                            cnt_d   = cnt_q + 5'd1;
                        end else begin
                            state_d = START;
                        end
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            FILL: begin
                busy     = 1'b1;
                mem_we   = 1'b1;
                mem_addr = cnt_q;
                if (cnt_q == 5'd31) begin
                    state_d = START;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            START: begin
                busy      = 1'b1;
                cpu_reset = 1'b0;
                cpu_start = 1'b1;
                state_d   = RUN;
            end
            RUN: begin
                done      = 1'b1;
                cpu_reset = 1'b0;
                mem_addr  = cpu_addr;
                mem_din   = cpu_wdata;
                mem_we    = cpu_we;
                if (load_req) begin
                    state_d = LOAD;
                    len_d   = len_sel;
                    cnt_d   = 5'd0;
                    sum_d   = 8'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: one instance with zero-fill, one without,
// both driven by the same stimulus.
module tb_prog_loader;
    logic       clk = 1'b0;
    logic       reset;
    logic       load_req;
    logic [5:0] load_len;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic [4:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_we;

    logic       byte_ready, mem_we, cpu_reset, cpu_start, busy, done;
    logic [4:0] mem_addr;
    logic [7:0] mem_din, checksum;
    logic       nf_byte_ready, nf_mem_we, nf_cpu_reset, nf_cpu_start, nf_busy, nf_done;
    logic [4:0] nf_mem_addr;
    logic [7:0] nf_mem_din, nf_checksum;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    prog_loader #(.FILL_ZERO(1'b1)) dut (
        .clk(clk), .reset(reset), .load_req(load_req), .load_len(load_len),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
        .cpu_reset(cpu_reset), .cpu_start(cpu_start), .busy(busy),
        .done(done), .checksum(checksum)
    );

    prog_loader #(.FILL_ZERO(1'b0)) dut_nf (
        .clk(clk), .reset(reset), .load_req(load_req), .load_len(load_len),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(nf_byte_ready),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
        .mem_addr(nf_mem_addr), .mem_din(nf_mem_din), .mem_we(nf_mem_we),
        .cpu_reset(nf_cpu_reset), .cpu_start(nf_cpu_start), .busy(nf_busy),
        .done(nf_done), .checksum(nf_checksum)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        load_req   = 1'b0;
        load_len   = 6'd0;
        byte_in    = 8'd0;
        byte_valid = 1'b0;
        cpu_addr   = 5'd0;
        cpu_wdata  = 8'd0;
        cpu_we     = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [26:0] exp_v;
        do_reset();
        reset = 1'b1;
        tick();
        #1;
        exp_v = {1'b0, 5'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        total++;
        if ({byte_ready, mem_addr, mem_din, mem_we, cpu_reset, cpu_start, busy, done, checksum} !== exp_v) begin
            bad++;
            $display("[TB] FAIL reset_outputs got=%h want=%h",
                     {byte_ready, mem_addr, mem_din, mem_we, cpu_reset, cpu_start, busy, done, checksum}, exp_v);
        end
        total++;
        if ({nf_byte_ready, nf_mem_addr, nf_mem_din, nf_mem_we, nf_cpu_reset, nf_cpu_start, nf_busy, nf_done, nf_checksum} !== exp_v) begin
            bad++;
            $display("[TB] FAIL reset_outputs_nofill got=%h want=%h",
                     {nf_byte_ready, nf_mem_addr, nf_mem_din, nf_mem_we, nf_cpu_reset, nf_cpu_start, nf_busy, nf_done, nf_checksum}, exp_v);
        end
        reset      = 1'b0;
        byte_valid = 1'b1;
        byte_in    = 8'h5A;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if ({mem_we, byte_ready, cpu_reset} !== 3'b001) begin
                bad++;
                $display("[TB] FAIL idle_hold cycle=%0d got we/ready/cpurst=%b want=001", i, {mem_we, byte_ready, cpu_reset});
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic test_fill();
        logic [7:0] img [4];
        img = '{8'h11, 8'h22, 8'h33, 8'hF0};
        do_reset();
        load_req = 1'b1;
        load_len = 6'd4;
        tick();
        load_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            byte_in    = img[i];
            byte_valid = 1'b1;
            #1;
            total++;
            if ({byte_ready, mem_we, mem_addr, mem_din} !== {1'b1, 1'b1, 5'(i), img[i]}) begin
                bad++;
                $display("[TB] FAIL load_write i=%0d got=%h want=%h", i,
                         {byte_ready, mem_we, mem_addr, mem_din}, {1'b1, 1'b1, 5'(i), img[i]});
            end
            tick();
        end
        byte_valid = 1'b0;
        #1;
        total++;
        if ({nf_cpu_start, nf_mem_we} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL nofill_start got start/we=%b want=10", {nf_cpu_start, nf_mem_we});
        end
        for (int i = 0; i < 28; i++) begin
            total++;
            if ({mem_we, mem_addr, mem_din, cpu_start, cpu_reset} !== {1'b1, 5'(4 + i), 8'h00, 1'b0, 1'b1}) begin
                bad++;
                $display("[TB] FAIL fill_write i=%0d got=%h want=%h", i,
                         {mem_we, mem_addr, mem_din, cpu_start, cpu_reset}, {1'b1, 5'(4 + i), 8'h00, 1'b0, 1'b1});
            end
            tick();
        end
        total++;
        if ({cpu_start, mem_we, cpu_reset, busy, done} !== 5'b10010) begin
            bad++;
            $display("[TB] FAIL fill_start got=%b want=10010", {cpu_start, mem_we, cpu_reset, busy, done});
        end
        tick();
        total++;
        if ({cpu_start, done, busy, cpu_reset} !== 4'b0100) begin
            bad++;
            $display("[TB] FAIL fill_run got=%b want=0100", {cpu_start, done, busy, cpu_reset});
        end
        total++;
        if (checksum !== 8'h56) begin
            bad++;
            $display("[TB] FAIL fill_checksum got=%h want=56", checksum);
        end
        total++;
        if (nf_checksum !== 8'h56) begin
            bad++;
            $display("[TB] FAIL nofill_checksum got=%h want=56", nf_checksum);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] exp_sum;
        int         writes;
        do_reset();
        exp_sum  = 8'd0;
        writes   = 0;
        load_req = 1'b1;
        load_len = 6'd0;
        tick();
        load_req = 1'b0;
        for (int k = 0; k < 64; k++) begin
            byte_valid = k[0];
            byte_in    = 8'(k * 13 + 5);
            #1;
            if (byte_valid) begin
                exp_sum = exp_sum + byte_in;
                total++;
                if ({byte_ready, mem_we, mem_addr, mem_din} !== {1'b1, 1'b1, 5'(k / 2), byte_in}) begin
                    bad++;
                    $display("[TB] FAIL gap_write k=%0d got=%h want=%h", k,
                             {byte_ready, mem_we, mem_addr, mem_din}, {1'b1, 1'b1, 5'(k / 2), byte_in});
                end
            end else begin
                total++;
                if ({byte_ready, mem_we} !== 2'b10) begin
                    bad++;
                    $display("[TB] FAIL gap_idle k=%0d got ready/we=%b want=10", k, {byte_ready, mem_we});
                end
            end
            if (mem_we) writes++;
            tick();
        end
        byte_valid = 1'b0;
        #1;
        total++;
        if (writes != 32) begin
            bad++;
            $display("[TB] FAIL gap_write_count got=%0d want=32", writes);
        end
        total++;
        if ({cpu_start, mem_we, nf_cpu_start, nf_mem_we} !== 4'b1010) begin
            bad++;
            $display("[TB] FAIL gap_start got=%b want=1010", {cpu_start, mem_we, nf_cpu_start, nf_mem_we});
        end
        tick();
        total++;
        if ({done, checksum} !== {1'b1, exp_sum}) begin
            bad++;
            $display("[TB] FAIL gap_checksum got=%h want=%h", {done, checksum}, {1'b1, exp_sum});
        end
    endtask

    task automatic test_passthrough();
        logic [7:0] exp_sum;
        do_reset();
        exp_sum  = 8'd0;
        load_req = 1'b1;
        load_len = 6'd40;
        tick();
        load_req   = 1'b0;
        byte_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            byte_in = 8'(255 - i * 3);
            exp_sum = exp_sum + byte_in;
            tick();
        end
        byte_valid = 1'b0;
        #1;
        total++;
        if ({nf_cpu_start, nf_mem_we, cpu_start} !== 3'b101) begin
            bad++;
            $display("[TB] FAIL len40_start got=%b want=101", {nf_cpu_start, nf_mem_we, cpu_start});
        end
        tick();
        cpu_addr  = 5'd9;
        cpu_wdata = 8'hAB;
        cpu_we    = 1'b1;
        #1;
        total++;
        if ({nf_done, nf_mem_addr, nf_mem_din, nf_mem_we} !== {1'b1, 5'd9, 8'hAB, 1'b1}) begin
            bad++;
            $display("[TB] FAIL run_pass got=%h want=%h",
                     {nf_done, nf_mem_addr, nf_mem_din, nf_mem_we}, {1'b1, 5'd9, 8'hAB, 1'b1});
        end
        total++;
        if (nf_checksum !== exp_sum) begin
            bad++;
            $display("[TB] FAIL len40_checksum got=%h want=%h", nf_checksum, exp_sum);
        end
        cpu_addr  = 5'd17;
        cpu_wdata = 8'h3C;
        cpu_we    = 1'b0;
        #1;
        total++;
        if ({mem_addr, mem_din, mem_we} !== {5'd17, 8'h3C, 1'b0}) begin
            bad++;
            $display("[TB] FAIL run_pass2 got=%h want=%h", {mem_addr, mem_din, mem_we}, {5'd17, 8'h3C, 1'b0});
        end
    endtask

    task automatic test_reload();
        logic [7:0] img [3];
        img = '{8'h01, 8'h80, 8'h90};
        cpu_addr  = 5'd9;
        cpu_wdata = 8'hAB;
        cpu_we    = 1'b1;
        load_req  = 1'b1;
        load_len  = 6'd3;
        tick();
        load_len   = 6'd10;
        byte_valid = 1'b0;
        #1;
        total++;
        if ({nf_cpu_reset, nf_byte_ready, nf_done, nf_mem_we} !== 4'b1100) begin
            bad++;
            $display("[TB] FAIL reload_entry got=%b want=1100", {nf_cpu_reset, nf_byte_ready, nf_done, nf_mem_we});
        end
        total++;
        if (nf_checksum !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reload_clear got=%h want=00", nf_checksum);
        end
        for (int i = 0; i < 3; i++) begin
            byte_in    = img[i];
            byte_valid = 1'b1;
            tick();
        end
        byte_valid = 1'b0;
        load_req   = 1'b0;
        cpu_we     = 1'b0;
        #1;
        total++;
        if ({nf_cpu_start, nf_checksum} !== {1'b1, 8'h11}) begin
            bad++;
            $display("[TB] FAIL reload_len got=%h want=%h", {nf_cpu_start, nf_checksum}, {1'b1, 8'h11});
        end
    endtask

    task automatic test_reset_mid();
        logic seen_start;
        do_reset();
        seen_start = 1'b0;
        load_req   = 1'b1;
        load_len   = 6'd6;
        tick();
        load_req   = 1'b0;
        byte_valid = 1'b1;
        byte_in    = 8'h40;
        tick();
        byte_in = 8'h07;
        tick();
        byte_in = 8'h99;
        #1;
        total++;
        if ({busy, checksum} !== {1'b1, 8'h47}) begin
            bad++;
            $display("[TB] FAIL partial_sum got=%h want=%h", {busy, checksum}, {1'b1, 8'h47});
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        total++;
        if ({cpu_reset, checksum, busy, byte_ready, cpu_start} !== {1'b1, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL midreset got=%h want=%h",
                     {cpu_reset, checksum, busy, byte_ready, cpu_start}, {1'b1, 8'h00, 1'b0, 1'b0, 1'b0});
        end
        for (int i = 0; i < 10; i++) begin
            if (cpu_start || mem_we) seen_start = 1'b1;
            tick();
        end
        total++;
        if (seen_start !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midreset_quiet got=%b want=0", seen_start);
        end
        byte_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        test_reset();
        test_fill();
        test_gaps();
        test_passthrough();
        test_reload();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
# prog_loader

Program loader and memory-port owner for the MP-8 processor. After reset it holds the processor in reset. On request it streams a program image from an external byte source into the 32×8 program/data memory and optionally zero-fills the unused addresses. It then releases the processor and pulses its start input. While the processor runs, the block passes the processor's memory accesses straight through to the single memory port.

## Interface
Parameters:
- FILL_ZERO, 1: when 1, addresses from len to 31 are written with 8'h00 after the load; when 0, the fill phase is skipped.

Ports:
- clk  in  1  system clock; single clock domain, rising edge.
- reset  in  1  synchronous, active-high reset.
- load_req  in  1  load request, single-cycle or level; sampled only in IDLE or RUN.
- load_len  in  6  number of bytes to load, sampled with load_req; 0 or >32 means 32.
- byte_in  in  8  image byte.
- byte_valid  in  1  byte_in holds a valid byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- cpu_addr  in  5  processor memory address.
- cpu_wdata  in  8  processor write data (accumulator).
- cpu_we  in  1  processor memory write.
- mem_addr  out  5  memory port address.
- mem_din  out  8  memory port write data.
- mem_we  out  1  memory port write enable.
- cpu_reset  out  1  drives the processor's reset input.
- cpu_start  out  1  one-cycle start pulse to the processor.
- busy  out  1  high in LOAD, FILL and START.
- done  out  1  high in RUN.
- checksum  out  8  modulo-256 sum of the bytes accepted in the last load.

## Operation
- State machine states: IDLE, LOAD, FILL, START, RUN. Reset puts the block in IDLE.
- IDLE:
  - cpu_reset=1; memory port idle (mem_we=0, mem_addr=0, mem_din=0).
  - load_req → LOAD. On this transition: len register = (load_len==0 || load_len>32) ? 32 : load_len; address counter=0; checksum=0.
- LOAD:
  - byte_ready=1; cpu_reset=1.
  - mem_addr=counter; mem_din=byte_in; mem_we=byte_valid (combinational).
  - Each transfer (byte_valid & byte_ready): checksum += byte_in (8-bit wrap), counter += 1.
  - On the transfer of byte len-1: go to FILL if FILL_ZERO=1 and len<32, otherwise go to START.
- FILL:
  - mem_we=1, mem_din=0, mem_addr=counter; one address per cycle.
  - After address 31 is written → START. The counter never wraps past 31.
- START:
  - Lasts exactly 1 cycle. cpu_reset=0, cpu_start=1, mem_we=0. Then → RUN.
- RUN:
  - cpu_reset=0; mem_addr=cpu_addr, mem_din=cpu_wdata, mem_we=cpu_we (combinational passthrough).
  - load_req → LOAD, with the same sampling as in IDLE. cpu_reset rises in the first LOAD cycle, and the processor's memory accesses are blocked from that cycle onward.
- load_req is ignored in LOAD, FILL and START.
- byte_valid is ignored outside LOAD; byte_ready=0 outside LOAD.
- reset in any state: next cycle is IDLE with all reset values. A partial image stays in memory; the checksum clears.

## Timing
- Reset values: byte_ready=0, mem_addr=0, mem_din=0, mem_we=0, cpu_reset=1, cpu_start=0, busy=0, done=0, checksum=0.
- Latency from load_req to first byte_ready: 1 cycle.
- Memory writes in LOAD happen in the same cycle as the handshake. There is no buffering, and byte_valid gaps insert idle cycles.
- With no byte_valid gaps, LOAD→START takes len + (FILL_ZERO ? 32−len : 0) cycles. cpu_start is asserted in the cycle after the last memory write.
- checksum updates at the clock edge of each transfer and holds through START and RUN.
- cpu_start never coincides with mem_we=1.
- In RUN, the memory port equals the cpu_* inputs in the same cycle.

## Test plan
- Reset → check every output against its reset value. Hold IDLE for 10 cycles with byte_valid=1 → mem_we stays 0 and byte_ready stays 0.
- FILL_ZERO=1, load_len=4, bytes 8'h11,8'h22,8'h33,8'hF0 with no gaps:
  - Writes to addresses 0–3 with those values, then 28 zero writes to addresses 4–31.
  - cpu_start for exactly 1 cycle, then done=1 and checksum=8'h56.
- load_len=0, 32 bytes with byte_valid low every other cycle:
  - Exactly 32 writes to addresses 0–31 and no FILL cycles.
  - Every byte_ready&&!byte_valid cycle has mem_we=0.
  - START follows the last write by 1 cycle.
- FILL_ZERO=0, load_len=40 → treated as 32; no FILL. In RUN, drive cpu_addr=5'd9, cpu_wdata=8'hAB, cpu_we=1 → mem_addr=9, mem_din=8'hAB, mem_we=1 in the same cycle.
- load_req in RUN → the next cycle shows cpu_reset=1, byte_ready=1 and done=0, and cpu_we=1 does not reach mem_we. A second load_req during LOAD is ignored and len is unchanged.
- reset asserted after 2 of 6 bytes → next cycle is IDLE: cpu_reset=1, checksum=0, no cpu_start ever observed.
